// File: rtl/sd_card_emu.sv
// Purpose: SPI-mode SD card emulator. It decodes CMD0/8/16/17/41/55/58 and serves CMD17
//          block reads with a generated byte pattern.
// Latency: the response follows one 0xFF NCR byte, sent after the command's final bit.
//          CMD17 data follows one 0xFF NAC byte and the 0xFE start token.
// Backpressure: none. The host owns the clock. cs=1 on any rising edge aborts the transfer,
//          and the card state is retained.
// Ports: clk (SPI clock), rst (async, active-low), cs (active-low select), mosi (host
//        data in, MSB first), miso (card data out, MSB first, 1 when not transmitting).
module sd_card_emu #(
    parameter int          BLOCK_LEN = 512,
    parameter logic [31:0] OCR       = 32'hC0FF8000
) (
    input  logic clk,
    input  logic rst,
    input  logic cs,
    input  logic mosi,
    output logic miso
);
    localparam int CNT_W = $clog2(BLOCK_LEN + 1);

    typedef enum logic [2:0] {
        RX_WAIT, RX_CMD, TX_NCR, TX_RESP, TX_NAC, TX_TOKEN, TX_DATA, TX_CRC
    } state_t;

    state_t           state;
    logic             in_idle;
    logic             app_cmd;
    logic             prev_zero;    // previous sampled bit was 0 (first half of start sequence)
    logic [5:0]       rx_cnt;
    logic [17:0]      cmd_sh;       // {index[5:0], arg[11:0]}: the only command bits ever used
    logic [2:0]       bit_cnt;
    logic [7:0]       tx_byte;
    logic [39:0]      resp_buf;     // pending response bytes, left-aligned
    logic [2:0]       resp_left;    // bytes still queued in resp_buf after the current one
    logic             data_phase;
    logic [CNT_W-1:0] byte_cnt;
    logic             miso_q;
    logic             tx_en_q;
    logic             tx_state;
    logic             keep_bit;

    // Decoded command, evaluated while the final command bit is being sampled
    logic [5:0]  cmd_idx;
    logic [7:0]  r1;
    logic [39:0] dec_resp;
    logic [2:0]  dec_left;
    logic        dec_data;
    logic        dec_idle;
    logic        dec_app;

    assign tx_state = (state != RX_WAIT) && (state != RX_CMD);
    assign cmd_idx  = cmd_sh[17:12];
    assign r1       = {7'b0, in_idle};
    // Bit 0 of RX_CMD is index[5]. arg[11:0] arrives on bits 26..37. Other arg bits are dropped.
    assign keep_bit = (rx_cnt < 6'd6) || ((rx_cnt >= 6'd26) && (rx_cnt < 6'd38));

    always_comb begin
        dec_resp = {r1, 32'h0};
        dec_left = 3'd0;
        dec_data = 1'b0;
        dec_idle = in_idle;
        dec_app  = 1'b0;
        case (cmd_idx)
            6'd0: begin
                dec_resp = {8'h01, 32'h0};
                dec_idle = 1'b1;
            end
            6'd8: begin
                dec_resp = {(in_idle ? 8'h01 : 8'h00), 16'h0000, 4'h0, cmd_sh[11:8], cmd_sh[7:0]};
                dec_left = 3'd4;
            end
            6'd55: dec_app = 1'b1;
            6'd41: begin
                if (app_cmd) begin
                    dec_resp = 40'h0;
                    dec_idle = 1'b0;
                end else begin
                    dec_resp = {8'h04 | r1, 32'h0};
                end
            end
            6'd58: begin
                dec_resp = {r1, OCR};
                dec_left = 3'd4;
            end
            6'd16: dec_resp = {r1, 32'h0};
            6'd17: dec_data = ~in_idle;          // R1 is 0x01 and no data while IDLE
            default: dec_resp = {8'h04 | r1, 32'h0};
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RX_WAIT;
            in_idle    <= 1'b1;
            app_cmd    <= 1'b0;
            prev_zero  <= 1'b0;
            rx_cnt     <= 6'd0;
            cmd_sh     <= 18'd0;
            bit_cnt    <= 3'd0;
            tx_byte    <= 8'd0;
            resp_buf   <= 40'd0;
            resp_left  <= 3'd0;
            data_phase <= 1'b0;
            byte_cnt   <= '0;
        end else if (cs) begin
            state     <= RX_WAIT;
            prev_zero <= 1'b0;
            rx_cnt    <= 6'd0;
            bit_cnt   <= 3'd0;
            byte_cnt  <= '0;
        end else begin
            case (state)
                RX_WAIT: begin
                    prev_zero <= ~mosi;
                    if (prev_zero && mosi) begin
                        state     <= RX_CMD;
                        rx_cnt    <= 6'd0;
                        prev_zero <= 1'b0;
                    end
                end
                RX_CMD: begin
                    if (keep_bit) cmd_sh <= {cmd_sh[16:0], mosi};
                    rx_cnt <= rx_cnt + 6'd1;
                    if (rx_cnt == 6'd45) begin
                        state      <= TX_NCR;
                        rx_cnt     <= 6'd0;
                        bit_cnt    <= 3'd0;
                        tx_byte    <= 8'hFF;
                        resp_buf   <= dec_resp;
                        resp_left  <= dec_left;
                        data_phase <= dec_data;
                        in_idle    <= dec_idle;
                        app_cmd    <= dec_app;
                    end
                end
                default: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        case (state)
                            TX_NCR: begin
                                state    <= TX_RESP;
                                tx_byte  <= resp_buf[39:32];
                                resp_buf <= {resp_buf[31:0], 8'h00};
                            end
                            TX_RESP: begin
                                if (resp_left != 3'd0) begin
                                    tx_byte   <= resp_buf[39:32];
                                    resp_buf  <= {resp_buf[31:0], 8'h00};
                                    resp_left <= resp_left - 3'd1;
                                end else if (data_phase) begin
                                    state   <= TX_NAC;
                                    tx_byte <= 8'hFF;
                                end else begin
                                    state <= RX_WAIT;
                                end
                            end
                            TX_NAC: begin
                                state   <= TX_TOKEN;
                                tx_byte <= 8'hFE;
                            end
                            TX_TOKEN: begin
                                state    <= TX_DATA;
                                tx_byte  <= cmd_sh[7:0];
                                byte_cnt <= '0;
                            end
                            TX_DATA: begin
                                if (byte_cnt == CNT_W'(BLOCK_LEN - 1)) begin
                                    state    <= TX_CRC;
                                    tx_byte  <= 8'hFF;
                                    byte_cnt <= '0;
                                end else begin
                                    byte_cnt <= byte_cnt + CNT_W'(1);
                                    tx_byte  <= tx_byte + 8'd1;   // pattern wraps at 256
                                end
                            end
                            TX_CRC: begin
                                if (byte_cnt == '0) begin
                                    byte_cnt <= CNT_W'(1);
                                    tx_byte  <= 8'hFF;
                                end else begin
                                    state    <= RX_WAIT;
                                    byte_cnt <= '0;
                                end
                            end
                            default: state <= RX_WAIT;
                        endcase
                    end
                end
            endcase
        end
    end

    // miso changes on the falling edge so the host can sample it on the next rising edge
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            miso_q  <= 1'b1;
            tx_en_q <= 1'b0;
        end else begin
            tx_en_q <= tx_state;
            miso_q  <= tx_byte[~bit_cnt];
        end
    end

    assign miso = cs | ~tx_en_q | miso_q;

endmodule

// File: tb/tb_sd_card_emu.sv
module tb_sd_card_emu;
    localparam int          BLK   = 512;
    localparam logic [31:0] OCR_V = 32'hC0FF8000;

    logic clk  = 1'b0;
    logic rst  = 1'b0;
    logic cs   = 1'b0;
    logic mosi = 1'b1;
    logic miso;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference card model
    logic       m_idle = 1'b1;
    logic       m_app  = 1'b0;
    logic [7:0] exp_q[$];

    sd_card_emu #(.BLOCK_LEN(BLK), .OCR(OCR_V)) dut (
        .clk  (clk),
        .rst  (rst),
        .cs   (cs),
        .mosi (mosi),
        .miso (miso)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected miso bytes after a command: NCR, response, optional data phase
    function automatic void model_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [7:0] r1;
        r1 = m_idle ? 8'h01 : 8'h00;
        exp_q.delete();
        exp_q.push_back(8'hFF);
        case (idx)
            6'd0: begin
                exp_q.push_back(8'h01);
                m_idle = 1'b1;
            end
            6'd8: begin
                exp_q.push_back(r1);
                exp_q.push_back(8'h00);
                exp_q.push_back(8'h00);
                exp_q.push_back((arg >> 8) & 32'h0F);
                exp_q.push_back(arg & 32'hFF);
            end
            6'd55: exp_q.push_back(r1);
            6'd41: begin
                if (m_app) begin
                    exp_q.push_back(8'h00);
                    m_idle = 1'b0;
                end else begin
                    exp_q.push_back(r1 | 8'h04);
                end
            end
            6'd58: begin
                exp_q.push_back(r1);
                for (int s = 24; s >= 0; s -= 8) exp_q.push_back((OCR_V >> s) & 32'hFF);
            end
            6'd16: exp_q.push_back(r1);
            6'd17: begin
                if (m_idle) begin
                    exp_q.push_back(8'h01);
                end else begin
                    exp_q.push_back(8'h00);
                    exp_q.push_back(8'hFF);
                    exp_q.push_back(8'hFE);
                    for (int i = 0; i < BLK; i++) exp_q.push_back(((arg & 32'hFF) + i) % 256);
                    exp_q.push_back(8'hFF);
                    exp_q.push_back(8'hFF);
                end
            end
            default: exp_q.push_back(r1 | 8'h04);
        endcase
        m_app = (idx == 6'd55);
    endfunction

    // One SPI byte: mosi set after the falling edge, miso read after it has settled
    task automatic xfer_byte(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            #1;
            rx[i] = miso;
            mosi  = tx[i];
        end
    endtask

    task automatic idle_bytes(input int n, input logic cs_val);
        logic [7:0] rx;
        cs = cs_val;
        for (int i = 0; i < n; i++) begin
            xfer_byte(8'hFF, rx);
            chk("idle", rx, 8'hFF);
        end
    endtask

    // Sends a command; limit < 0 reads the whole expected reply plus one idle byte
    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int limit);
        logic [7:0] cb[6];
        logic [7:0] rx;
        int         n;
        model_cmd(idx, arg);
        cb[0] = {2'b01, idx};
        cb[1] = arg[31:24];
        cb[2] = arg[23:16];
        cb[3] = arg[15:8];
        cb[4] = arg[7:0];
        cb[5] = 8'($urandom_range(0, 255)) | 8'h01;
        cs = 1'b0;
        for (int i = 0; i < 6; i++) begin
            xfer_byte(cb[i], rx);
            chk("cmd_phase", rx, 8'hFF);
        end
        n = (limit < 0) ? exp_q.size() : limit;
        for (int k = 0; k < n; k++) begin
            xfer_byte(8'hFF, rx);
            chk($sformatf("cmd%0d_b%0d", idx, k), rx, exp_q[k]);
        end
        if (limit < 0) idle_bytes(1, 1'b0);
    endtask

    initial begin
        logic [7:0] rx;
        logic [5:0] idx;
        int         pick;
        int         reads;

        // Reset with cs low: miso must still idle high
        rst = 1'b0;
        cs  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("reset_miso", miso, 1'b1);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        idle_bytes(2, 1'b0);

        // Initialisation sequence
        do_cmd(6'd0, 32'h0, -1);
        do_cmd(6'd8, 32'h000001AA, -1);
        do_cmd(6'd55, 32'h0, -1);
        do_cmd(6'd41, 32'h40000000, -1);
        do_cmd(6'd55, 32'h0, -1);
        do_cmd(6'd58, 32'h0, -1);
        do_cmd(6'd16, 32'h00000200, -1);

        // Full block read with the pattern wrapping past 0xFF, then CMD0
        do_cmd(6'd17, 32'h00000010, -1);
        do_cmd(6'd0, 32'h0, -1);
        do_cmd(6'd17, 32'h00000020, -1);
        do_cmd(6'd5, 32'h0, -1);
        do_cmd(6'd55, 32'h0, -1);
        do_cmd(6'd41, 32'h0, -1);

        // Abort a read after 20 data bytes; data byte 20 is 0x14 so miso is low before cs rises
        do_cmd(6'd17, 32'h12345600, 24);
        @(negedge clk);
        #1;
        chk("abort_pre", miso, 1'b0);
        cs = 1'b1;
        #1;
        chk("abort_miso", miso, 1'b1);
        idle_bytes(2, 1'b1);
        idle_bytes(1, 1'b0);
        do_cmd(6'd58, 32'h0, -1);

        do_cmd(6'd5, 32'hFFFFFFFF, -1);
        do_cmd(6'd41, 32'h0, -1);

        // A CMD0 sent with cs high must not reset the card
        cs = 1'b1;
        xfer_byte(8'h40, rx);
        for (int i = 0; i < 4; i++) xfer_byte(8'h00, rx);
        xfer_byte(8'h95, rx);
        idle_bytes(2, 1'b1);
        idle_bytes(2, 1'b0);
        do_cmd(6'd55, 32'h0, -1);
        do_cmd(6'd0, 32'h0, -1);

        // Asynchronous reset in the middle of an R7 (byte 2 is 0x00)
        do_cmd(6'd55, 32'h0, -1);
        do_cmd(6'd41, 32'h0, -1);
        do_cmd(6'd8, 32'h00000155, 2);
        @(negedge clk);
        #2;
        chk("rst_pre", miso, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_miso", miso, 1'b1);
        m_idle = 1'b1;
        m_app  = 1'b0;
        @(negedge clk);
        #1;
        rst = 1'b1;
        idle_bytes(1, 1'b0);
        do_cmd(6'd55, 32'h0, -1);
        do_cmd(6'd8, 32'h00000ABC, -1);

        // Randomized command stream against the model
        reads = 0;
        for (int t = 0; t < 40; t++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0: idx = 6'd0;
                1: idx = 6'd8;
                2, 7: idx = 6'd55;
                3: idx = 6'd41;
                4: idx = 6'd58;
                5: idx = 6'd16;
                6: idx = 6'd17;
                default: idx = 6'($urandom_range(0, 63));
            endcase
            if (idx == 6'd17 && !m_idle) begin
                if (reads >= 2) idx = 6'd58;
                else reads++;
            end
            if ($urandom_range(0, 3) == 0) idle_bytes(1, 1'b1);
            idle_bytes($urandom_range(0, 1), 1'b0);
            do_cmd(idx, $urandom, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
